// File: rtl/scan_decoder_pkg.sv
// rtl/scan_decoder_pkg.sv - shared constants and helpers for the scan decoder
package scan_decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Widest decoded bus the polarity helper handles (SEL_W up to 8).
    localparam int MAX_N = 256;

    function automatic int clog2(input int value);
        int bits;
        int rest;
        bits = 0;
        rest = value - 1;
        while (rest > 0) begin
            bits = bits + 1;
            rest = rest >> 1;
        end
        return bits;
    endfunction

    function automatic logic [MAX_N-1:0] apply_polarity(input logic [MAX_N-1:0] bits,
                                                        input logic active_low);
        return bits ^ {MAX_N{active_low}};
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// rtl/scan_decoder_if.sv - control and decoded-output bundle of the scan decoder
interface scan_decoder_if #(
    parameter int SEL_W = 2
);
    localparam int N = 2 ** SEL_W;

    logic             enable;
    logic             mode;
    logic [SEL_W-1:0] sel_in;
    logic             blank;
    logic [N-1:0]     out;
    logic [SEL_W-1:0] cur_sel;
    logic             wrap;

    modport master (
        output enable, mode, sel_in, blank,
        input  out, cur_sel, wrap
    );

    modport slave (
        input  enable, mode, sel_in, blank,
        output out, cur_sel, wrap
    );

endinterface

// File: rtl/scan_decoder_onehot_decoder.sv
// rtl/scan_decoder_onehot_decoder.sv - combinational SEL_W to 2**SEL_W one-hot decode
module onehot_decoder #(
    parameter  int SEL_W = 2,
    localparam int N     = 2 ** SEL_W
) (
    input  logic [SEL_W-1:0] sel,
    input  logic             valid,
    output logic [N-1:0]     onehot
);

    always_comb begin
        onehot = '0;
        if (valid) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered direct/scan select decoder with prescaled round-robin and guard time
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter int CHANNELS   = 4,
    parameter int PRESCALE   = 100000,
    parameter int GUARD      = 0,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input logic          clk,
    input logic          reset_n,
    scan_decoder_if.slave bus
);

    localparam int               N          = 2 ** SEL_W;
    localparam int               PW         = clog2(PRESCALE);
    localparam logic [PW-1:0]    PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(CHANNELS - 1);
    localparam logic [N-1:0]     INACTIVE   = {N{ACTIVE_LOW}};

    if (CHANNELS < 1 || CHANNELS > N) begin : g_bad_channels
        $error("scan_decoder: CHANNELS must be within 1..2**SEL_W");
    end
    if (PRESCALE < 2) begin : g_bad_prescale
        $error("scan_decoder: PRESCALE must be at least 2");
    end
    if (GUARD < 0 || GUARD >= PRESCALE) begin : g_bad_guard
        $error("scan_decoder: GUARD must be within 0..PRESCALE-1");
    end
    if (N > MAX_N) begin : g_bad_width
        $error("scan_decoder: SEL_W too wide for polarity helper");
    end

    logic [PW-1:0]    presc_q, presc_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             mode_q, mode_d;
    logic             wrap_q, wrap_d;
    logic [N-1:0]     out_q, out_d;
    logic [SEL_W-1:0] cur_sel_q, cur_sel_d;

    logic             guard_hit;
    logic             in_range;
    logic [SEL_W-1:0] dec_sel;
    logic             dec_valid;
    logic [N-1:0]     onehot;

    // Counters advance only when enabled in scan mode; a rising mode restarts the scan.
    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        wrap_d  = 1'b0;
        if (bus.enable) begin
            mode_d = bus.mode;
            if (bus.mode == MODE_SCAN) begin
                if (mode_q == MODE_DIRECT) begin
                    presc_d = '0;
                    idx_d   = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx_q + SEL_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
        end
    end

    // Guard is judged on the prescaler value being registered alongside out.
    if (GUARD == 0) begin : g_no_guard
        assign guard_hit = 1'b0;
    end else begin : g_guard
        assign guard_hit = (presc_d < PW'(GUARD));
    end

    assign in_range = ({1'b0, bus.sel_in} < (SEL_W + 1)'(CHANNELS));

    always_comb begin
        dec_sel   = idx_d;
        dec_valid = !guard_hit;
        cur_sel_d = idx_d;
        if (bus.mode == MODE_DIRECT) begin
            dec_sel   = bus.sel_in;
            dec_valid = in_range;
            cur_sel_d = bus.sel_in;
        end
        if (!bus.enable) begin
            cur_sel_d = cur_sel_q;
        end
    end

    onehot_decoder #(
        .SEL_W (SEL_W)
    ) u_onehot_decoder (
        .sel    (dec_sel),
        .valid  (dec_valid),
        .onehot (onehot)
    );

    always_comb begin
        out_d = N'(apply_polarity(MAX_N'(onehot), ACTIVE_LOW));
        if (!bus.enable || bus.blank) begin
            out_d = INACTIVE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            mode_q    <= MODE_DIRECT;
            wrap_q    <= 1'b0;
            out_q     <= INACTIVE;
            cur_sel_q <= '0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            mode_q    <= mode_d;
            wrap_q    <= wrap_d;
            out_q     <= out_d;
            cur_sel_q <= cur_sel_d;
        end
    end

    assign bus.out     = out_q;
    assign bus.cur_sel = cur_sel_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// tb/tb_scan_decoder.sv - directed self-checking bench for scan_decoder
module tb_scan_decoder;

    logic       clk;
    logic       reset_n;
    logic       enable;
    logic       mode;
    logic [1:0] sel_in;
    logic       blank;

    int vectors;
    int miscompares;

    scan_decoder_if #(.SEL_W(2)) ifa ();
    scan_decoder_if #(.SEL_W(2)) ifb ();

    assign ifa.enable = enable;
    assign ifa.mode   = mode;
    assign ifa.sel_in = sel_in;
    assign ifa.blank  = blank;
    assign ifb.enable = enable;
    assign ifb.mode   = mode;
    assign ifb.sel_in = sel_in;
    assign ifb.blank  = blank;

    // A: four channels, no guard. B: three channels, one guard cycle per dwell.
    scan_decoder #(
        .SEL_W(2), .CHANNELS(4), .PRESCALE(4), .GUARD(0), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    scan_decoder #(
        .SEL_W(2), .CHANNELS(3), .PRESCALE(4), .GUARD(1), .ACTIVE_LOW(1'b1)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    localparam logic [3:0] A_OUT [16] = '{4'b1110, 4'b1110, 4'b1110, 4'b1101,
                                          4'b1101, 4'b1101, 4'b1101, 4'b1011,
                                          4'b1011, 4'b1011, 4'b1011, 4'b0111,
                                          4'b0111, 4'b0111, 4'b0111, 4'b1110};
    localparam logic [1:0] A_SEL [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                                          2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    localparam logic [15:0] A_WRAP = 16'h8000;
    localparam logic [3:0] B_OUT [16] = '{4'b1110, 4'b1110, 4'b1110, 4'b1111,
                                          4'b1101, 4'b1101, 4'b1101, 4'b1111,
                                          4'b1011, 4'b1011, 4'b1011, 4'b1111,
                                          4'b1110, 4'b1110, 4'b1110, 4'b1111};
    localparam logic [1:0] B_SEL [16] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2,
                                          2'd2, 2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    localparam logic [15:0] B_WRAP = 16'h0800;
    localparam logic [1:0] BL_SEL [8] = '{2'd2, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1};
    localparam logic [7:0] BL_WRAP = 8'h04;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_sel(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n = 1'b0;
        enable  = 1'b1;
        mode    = 1'b1;
        sel_in  = 2'd0;
        blank   = 1'b0;

        repeat (3) step();
        chk_out("reset a_out", ifa.out, 4'b1111);
        chk_sel("reset a_sel", ifa.cur_sel, 2'd0);
        chk_bit("reset a_wrap", ifa.wrap, 1'b0);
        chk_out("reset b_out", ifb.out, 4'b1111);

        reset_n = 1'b1;
        step();
        chk_out("release a_out", ifa.out, 4'b1110);
        chk_out("release b_out guard", ifb.out, 4'b1111);
        chk_sel("release b_sel", ifb.cur_sel, 2'd0);
        chk_bit("release a_wrap", ifa.wrap, 1'b0);
        chk_bit("release b_wrap", ifb.wrap, 1'b0);

        for (int t = 0; t < 16; t++) begin
            step();
            chk_out($sformatf("scan t%0d a_out", t + 1), ifa.out, A_OUT[t]);
            chk_sel($sformatf("scan t%0d a_sel", t + 1), ifa.cur_sel, A_SEL[t]);
            chk_bit($sformatf("scan t%0d a_wrap", t + 1), ifa.wrap, A_WRAP[t]);
            chk_out($sformatf("scan t%0d b_out", t + 1), ifb.out, B_OUT[t]);
            chk_sel($sformatf("scan t%0d b_sel", t + 1), ifb.cur_sel, B_SEL[t]);
            chk_bit($sformatf("scan t%0d b_wrap", t + 1), ifb.wrap, B_WRAP[t]);
        end

        repeat (2) step();
        chk_out("pre-freeze b_out", ifb.out, 4'b1101);
        chk_sel("pre-freeze b_sel", ifb.cur_sel, 2'd1);

        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("freeze %0d b_out", i), ifb.out, 4'b1111);
            chk_sel($sformatf("freeze %0d b_sel", i), ifb.cur_sel, 2'd1);
            chk_bit($sformatf("freeze %0d b_wrap", i), ifb.wrap, 1'b0);
            chk_out($sformatf("freeze %0d a_out", i), ifa.out, 4'b1111);
        end
        enable = 1'b1;
        step();
        chk_out("resume1 b_out", ifb.out, 4'b1101);
        chk_sel("resume1 b_sel", ifb.cur_sel, 2'd1);
        step();
        chk_out("resume2 b_out guard", ifb.out, 4'b1111);
        chk_sel("resume2 b_sel", ifb.cur_sel, 2'd2);
        step();
        chk_out("resume3 b_out", ifb.out, 4'b1011);
        chk_sel("resume3 a_sel", ifa.cur_sel, 2'd1);

        blank = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk_out($sformatf("blank %0d b_out", i), ifb.out, 4'b1111);
            chk_sel($sformatf("blank %0d b_sel", i), ifb.cur_sel, BL_SEL[i]);
            chk_bit($sformatf("blank %0d b_wrap", i), ifb.wrap, BL_WRAP[i]);
            chk_out($sformatf("blank %0d a_out", i), ifa.out, 4'b1111);
        end
        chk_sel("blank end a_sel", ifa.cur_sel, 2'd3);
        blank = 1'b0;
        step();
        chk_out("unblank b_out", ifb.out, 4'b1101);
        chk_out("unblank a_out", ifa.out, 4'b0111);

        repeat (3) step();
        chk_sel("idx2 b_sel", ifb.cur_sel, 2'd2);
        chk_out("idx2 b_out", ifb.out, 4'b1011);

        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel_in = 2'(s);
            step();
            chk_out($sformatf("direct sel%0d a_out", s), ifa.out, ~(4'b0001 << s));
            chk_sel($sformatf("direct sel%0d a_sel", s), ifa.cur_sel, 2'(s));
            chk_out($sformatf("direct sel%0d b_out", s), ifb.out,
                    (s == 3) ? 4'b1111 : ~(4'b0001 << s));
            chk_sel($sformatf("direct sel%0d b_sel", s), ifb.cur_sel, 2'(s));
            chk_bit($sformatf("direct sel%0d a_wrap", s), ifa.wrap, 1'b0);
        end
        blank = 1'b1;
        step();
        chk_out("direct blank a_out", ifa.out, 4'b1111);
        chk_sel("direct blank a_sel", ifa.cur_sel, 2'd3);
        blank  = 1'b0;
        enable = 1'b0;
        step();
        chk_out("direct disable a_out", ifa.out, 4'b1111);
        enable = 1'b1;
        sel_in = 2'd1;
        step();
        chk_out("direct reenable a_out", ifa.out, 4'b1101);
        chk_out("direct reenable b_out", ifb.out, 4'b1101);

        mode = 1'b1;
        step();
        chk_out("reentry b_out guard", ifb.out, 4'b1111);
        chk_sel("reentry b_sel", ifb.cur_sel, 2'd0);
        chk_bit("reentry b_wrap", ifb.wrap, 1'b0);
        chk_out("reentry a_out", ifa.out, 4'b1110);
        chk_bit("reentry a_wrap", ifa.wrap, 1'b0);
        step();
        chk_out("reentry+1 b_out", ifb.out, 4'b1110);

        repeat (4) step();
        chk_out("mid-dwell b_out", ifb.out, 4'b1101);
        chk_sel("mid-dwell b_sel", ifb.cur_sel, 2'd1);

        reset_n = 1'b0;
        step();
        chk_out("midreset b_out", ifb.out, 4'b1111);
        chk_sel("midreset b_sel", ifb.cur_sel, 2'd0);
        chk_bit("midreset b_wrap", ifb.wrap, 1'b0);
        chk_out("midreset a_out", ifa.out, 4'b1111);
        reset_n = 1'b1;
        step();
        chk_out("post-reset b_out guard", ifb.out, 4'b1111);
        chk_out("post-reset a_out", ifa.out, 4'b1110);
        chk_sel("post-reset b_sel", ifb.cur_sel, 2'd0);
        step();
        chk_out("post-reset+1 b_out", ifb.out, 4'b1110);
        repeat (3) step();
        chk_out("post-reset advance b_out", ifb.out, 4'b1111);
        chk_sel("post-reset advance b_sel", ifb.cur_sel, 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
- Parametrised, registered successor to the team's 2-to-4 active-low decoder.
- Decodes a SEL_W-bit select into a 2^SEL_W one-hot or one-cold output in two modes:
  - direct mode: decodes the sel_in input.
  - scan mode: free-running, prescaled round-robin across CHANNELS outputs, with programmable guard (all-off) time between channel changes.
- Drives the display-anode multiplexing and peripheral-select lines of the processor model.

Parameters:
- SEL_W, 2, select width; output width N = 2**SEL_W.
- CHANNELS, 4, number of channels visited in scan mode (1..N); also the limit for valid direct selects.
- PRESCALE, 100000, clock cycles per channel dwell (>=2).
- GUARD, 0, all-off cycles inserted at the start of each dwell (0..PRESCALE-1).
- ACTIVE_LOW, 1, 1: selected output bit is 0 and inactive bits are 1; 0: polarity inverted.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- reset_n, input, 1, synchronous active-low reset.
- enable, input, 1, 0 forces all outputs inactive and freezes the scan counters.
- mode, input, 1, 0 = direct, 1 = scan.
- sel_in, input, SEL_W, select used in direct mode.
- blank, input, 1, forces all outputs inactive; counters keep running.
- out, output, N, registered decoded select lines.
- cur_sel, output, SEL_W, registered index currently driven (scan index or sel_in).
- wrap, output, 1, one-cycle pulse when the scan index wraps CHANNELS-1 -> 0.

Behaviour:
- Reset:
  - Synchronous, active-low, sampled on the rising edge of clk; dominates all other inputs.
  - Reset values: out = all inactive (all 1s if ACTIVE_LOW, else all 0s); cur_sel = 0; wrap = 0; scan index = 0; prescaler = 0.
  - Reset asserted mid-dwell aborts the dwell; the first cycle after release starts a fresh dwell at index 0.
- Latency:
  - All outputs are registered.
  - Input changes (sel_in, mode, enable, blank) appear on out exactly 1 cycle later.
- Inactive value: "inactive" means all bits at the deasserted polarity.
- Direct mode (mode=0):
  - out = decode(sel_in); cur_sel = sel_in.
  - sel_in >= CHANNELS gives out inactive; cur_sel still = sel_in.
  - The prescaler and scan index hold their values.
- Scan mode (mode=1):
  - The prescaler counts 0..PRESCALE-1, then returns to 0.
  - At prescaler == PRESCALE-1, the index advances on the next edge: index+1, or 0 if index == CHANNELS-1.
  - wrap is high for exactly the one cycle in which the newly registered index is 0 because of a wrap.
  - No wrap pulse on reset or on mode entry.
  - If CHANNELS == 1, wrap pulses once every PRESCALE cycles.
  - out is inactive while prescaler < GUARD; otherwise out = decode(index).
  - cur_sel = index throughout, including during guard.
- Mode entry: a 0 -> 1 transition on mode clears the prescaler and index to 0 on that edge. Scan therefore always starts at channel 0 with a full dwell (guard included).
- Mode exit: a 1 -> 0 transition switches to direct decode on the next edge. Scan state holds but is discarded on the next entry.
- enable = 0:
  - out is inactive and the prescaler and index freeze.
  - Re-enabling resumes from the frozen position; mode-entry clearing still applies if mode rose while disabled.
- blank = 1: out is inactive; counters, cur_sel and wrap continue normally.
- Priority: reset_n > enable > blank > guard > decode.
- Width rules:
  - Prescaler width is clog2(PRESCALE).
  - Index width is SEL_W.
  - No arithmetic overflow is permitted; wrap uses an explicit compare, never natural rollover (CHANNELS may be < N).
- Parameter checks: elaboration must fail if CHANNELS is outside 1..N, PRESCALE < 2, or GUARD >= PRESCALE.

Decomposition:
- Shared package scan_decoder_pkg:
  - MODE_DIRECT / MODE_SCAN constants.
  - A clog2 helper function.
  - A polarity-apply function: xor with {N{ACTIVE_LOW}}.
- One natural sub-module: onehot_decoder, a combinational, parametrised SEL_W -> N one-hot decode with an in-range valid input.
- The top level holds the prescaler, index, mode-edge register and output registers, and applies polarity.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with mode=1, enable=1 -> out=4'b1111, cur_sel=0, wrap=0. After release with PRESCALE=4, GUARD=0 -> out=4'b1110 one cycle after release.
- Direct decode, defaults with ACTIVE_LOW=1, mode=0, sweep sel_in 0..3 -> out=1110, 1101, 1011, 0111, each 1 cycle after the input change. With CHANNELS=3, sel_in=3 -> out=1111, cur_sel=3.
- Scan wrap, PRESCALE=4, GUARD=1, CHANNELS=3 -> per channel: 1 cycle of 1111, then 3 cycles of the channel pattern; sequence 1110 -> 1101 -> 1011 -> 1110. wrap high for exactly 1 cycle every 12 cycles, coincident with cur_sel returning to 0; no wrap on the initial entry.
- Freeze and resume: in scan at index 1 with prescaler=2, drop enable for 5 cycles -> out=1111 throughout, cur_sel holds 1. Re-enable -> the dwell completes after the remaining 2 cycles (out=1101 then advance to index 2).
- Blank vs. counters: blank=1 for 8 cycles in scan, PRESCALE=4 -> out=1111 throughout, cur_sel advances twice, wrap still pulses on time.
- Mode re-entry and reset mid-dwell: switch mode 1->0->1 at index 2 -> scan restarts at index 0 with a fresh guard. Assert reset_n=0 for 1 cycle mid-dwell -> the next cycle shows all-inactive, index 0, prescaler restarted.
